// File: rtl/oh_cell_pkg.sv
// Shared definitions for the standard-cell response checker.
// Holds the FSM state enum, common truth-table constants and the
// truth-table lookup function used by the checker.
package oh_cell_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2
    } oh_state_e;

    // Truth tables indexed by the input vector; bit i = expected z for vector i.
    // Two-input cells use vector = {a, b}.
    localparam logic [3:0] NAND2 = 4'b0111;
    localparam logic [3:0] NOR2  = 4'b0001;
    localparam logic [1:0] INV   = 2'b01;
    localparam logic [3:0] AND2  = 4'b1000;

    // Widest cell supported by the lookup helper.
    localparam int MAX_N = 8;

    // Expected cell output for a given vector. Callers zero-extend the table
    // and the vector to the helper's fixed widths.
    function automatic logic expected(input logic [(2**MAX_N)-1:0] truth,
                                      input logic [MAX_N-1:0]      vec);
        return truth[vec];
    endfunction

endpackage

// File: rtl/oh_cell_checker_if.sv
// Stimulus handshake between the vector source and the checker.
//   vec_valid : source has a vector on the cell inputs
//   vec       : vector currently driven onto the cell inputs
//   vec_ready : checker can accept a vector
// master = stimulus source, slave = checker.
interface oh_cell_checker_if #(
    parameter int N = 2
);
    logic         vec_valid;
    logic [N-1:0] vec;
    logic         vec_ready;

    modport master (
        output vec_valid,
        output vec,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec,
        output vec_ready
    );
endinterface

// File: rtl/oh_sat_counter.sv
// Saturating up-counter used for the mismatch count.
//   clk, reset : clock and synchronous active-high reset
//   clr        : synchronous clear (below reset)
//   inc        : count one event; holds at all-ones instead of wrapping
//   count      : current value
module oh_sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/oh_cell_checker.sv
// Response-side checker for standard-cell characterization.
// Accepts a vector over the stim handshake, waits SETTLE cycles for the cell
// to propagate, samples z and compares it with TRUTH[vector]. Accumulates a
// saturating error count, first-failure capture and vector coverage.
//
// state  | meaning
// IDLE   | ready for a vector; vec_ready = 1
// WAIT   | settle countdown running on cnt
// SAMPLE | compare z with the table and update statistics
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : synchronous clear of statistics (FSM keeps running)
//   stim        : vec_valid / vec / vec_ready handshake (slave side)
//   z           : cell output under test
//   err_count   : saturating mismatch count
//   fail        : sticky first-mismatch flag
//   fail_vec    : vector of the first mismatch
//   fail_z      : z observed at the first mismatch
//   seen        : coverage mask, bit i = vector i checked
//   done        : sticky, every vector checked at least once
//   pass        : done and no mismatch
module oh_cell_checker
    import oh_cell_pkg::*;
#(
    parameter int               N      = 2,
    parameter logic [2**N-1:0]  TRUTH  = 4'b0111,
    parameter int               SETTLE = 4,
    parameter int               CW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    oh_cell_checker_if.slave  stim,
    input  logic              z,
    output logic [CW-1:0]     err_count,
    output logic              fail,
    output logic [N-1:0]      fail_vec,
    output logic              fail_z,
    output logic [2**N-1:0]   seen,
    output logic              done,
    output logic              pass
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WAIT   = WAIT;
    localparam logic [1:0] S_SAMPLE = SAMPLE;

    // Counter is loaded with SETTLE-1 so that z is sampled SETTLE+1 edges
    // after acceptance (SETTLE-1 decrements, one edge to see zero, one in SAMPLE).
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [1:0]   state;
    logic [7:0]   cnt;
    logic [N-1:0] vec_q;
    logic         sample;
    logic         mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            vec_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (stim.vec_valid) begin
                        vec_q <= stim.vec;
                        cnt   <= SETTLE_M1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 8'd0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stim.vec_ready = (state == S_IDLE);
    assign sample         = (state == S_SAMPLE);

    // Compare against the latched vector; the live bus may already be moving.
    assign mismatch = (z != expected((2**MAX_N)'(TRUTH), MAX_N'(vec_q)));

    oh_sat_counter #(
        .CW (CW)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (sample && mismatch),
        .count (err_count)
    );

    // Clear shares the reset path here, so a sample coinciding with clear is dropped.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seen     <= '0;
            fail     <= 1'b0;
            fail_vec <= '0;
            fail_z   <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (sample) begin
                seen[vec_q] <= 1'b1;
                if (mismatch && !fail) begin
                    fail     <= 1'b1;
                    fail_vec <= vec_q;
                    fail_z   <= z;
                end
            end
            // Registered from seen, so done lags full coverage by one edge.
            if (&seen) begin
                done <= 1'b1;
            end
        end
    end

    assign pass = done && !fail;

endmodule

// File: tb/tb_oh_cell_checker.sv
// Randomized self-checking bench for oh_cell_checker with a nand2 cell model.
// Two checkers share the stimulus: one with the default 8-bit error counter
// and one with a 2-bit counter to exercise saturation.
module tb_oh_cell_checker;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    logic vec_valid;
    logic [1:0] vec;
    logic z_drv;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    oh_cell_checker_if #(.N(2)) if_a ();
    oh_cell_checker_if #(.N(2)) if_b ();

    assign if_a.vec_valid = vec_valid;
    assign if_a.vec       = vec;
    assign if_b.vec_valid = vec_valid;
    assign if_b.vec       = vec;

    logic [7:0] err_a;
    logic       fail_a, fail_z_a, done_a, pass_a;
    logic [1:0] fail_vec_a;
    logic [3:0] seen_a;

    logic [1:0] err_b;
    logic       fail_b, fail_z_b, done_b, pass_b;
    logic [1:0] fail_vec_b;
    logic [3:0] seen_b;

    oh_cell_checker #(.N(2), .TRUTH(4'b0111), .SETTLE(SETTLE), .CW(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .stim(if_a), .z(z_drv),
        .err_count(err_a), .fail(fail_a), .fail_vec(fail_vec_a), .fail_z(fail_z_a),
        .seen(seen_a), .done(done_a), .pass(pass_a)
    );

    oh_cell_checker #(.N(2), .TRUTH(4'b0111), .SETTLE(SETTLE), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .stim(if_b), .z(z_drv),
        .err_count(err_b), .fail(fail_b), .fail_vec(fail_vec_b), .fail_z(fail_z_b),
        .seen(seen_b), .done(done_b), .pass(pass_b)
    );

    wire rdy = if_a.vec_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: cell behaviour plus checker statistics.
    int unsigned m_err8, m_err2;
    bit          m_fail, m_fz, m_done;
    logic [1:0]  m_fvec;
    logic [3:0]  m_seen;

    function automatic logic cell_nand(input logic [1:0] v);
        return !(v[1] && v[0]);
    endfunction

    function automatic void model_clear();
        m_err8 = 0; m_err2 = 0; m_fail = 0; m_fz = 0; m_done = 0;
        m_fvec = 0; m_seen = 0;
    endfunction

    function automatic void model_sample(input logic [1:0] v, input logic zz);
        bit mis;
        mis = (zz !== cell_nand(v));
        m_seen[v] = 1'b1;
        if (mis) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3)   m_err2++;
            if (!m_fail) begin
                m_fail = 1; m_fvec = v; m_fz = zz;
            end
        end
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".ready"},     rdy,        1);
        check({ctx, ".err_count"}, err_a,      m_err8);
        check({ctx, ".err_cw2"},   err_b,      m_err2);
        check({ctx, ".fail"},      fail_a,     m_fail);
        check({ctx, ".fail_vec"},  fail_vec_a, m_fvec);
        check({ctx, ".fail_z"},    fail_z_a,   m_fz);
        check({ctx, ".seen"},      seen_a,     m_seen);
        check({ctx, ".done"},      done_a,     m_done);
        check({ctx, ".pass"},      pass_a,     m_done && !m_fail);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; vec_valid = 0; clear = 0;
        repeat (2) @(negedge clk);
        model_clear();
        check_all("reset");
        reset = 0;
    endtask

    // One full vector transaction, then one idle cycle and a full compare.
    task automatic apply_vec(input logic [1:0] v, input logic flip);
        int low;
        @(negedge clk);
        check("ready_before", rdy, 1);
        vec = v; vec_valid = 1; z_drv = cell_nand(v) ^ flip;
        @(negedge clk);
        vec_valid = 0;
        low = 0;
        while (rdy == 0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check("ready_low_cycles", low, SETTLE + 1);
        check("done_lag", done_a, m_done);
        model_sample(v, z_drv);
        @(negedge clk);
        m_done = m_done | (&m_seen);
        check_all("vec");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f_cyc[2];
        int nf, guard, low;
        logic prev;
        logic xflag;

        reset = 1; clear = 0; vec_valid = 0; vec = 0; z_drv = 0;
        model_clear();

        // Reset values and happy path
        do_reset();
        for (int i = 0; i < 4; i++) apply_vec(2'(i), 1'b0);
        check("happy.err", err_a, 0);
        check("happy.seen", seen_a, 4'b1111);
        check("happy.pass", pass_a, 1);

        // Injected faults: vector 3 reads 1, vector 0 reads 0
        do_reset();
        apply_vec(2'd3, 1'b1);
        apply_vec(2'd1, 1'b0);
        apply_vec(2'd2, 1'b0);
        apply_vec(2'd0, 1'b1);
        check("fault.err", err_a, 2);
        check("fault.fail_vec", fail_vec_a, 2'b11);
        check("fault.fail_z", fail_z_a, 1);
        check("fault.done", done_a, 1);
        check("fault.pass", pass_a, 0);

        // Saturation with a stuck-at-1 output on vector 3
        do_reset();
        for (int i = 0; i < 6; i++) apply_vec(2'd3, 1'b1);
        check("sat.err_cw2", err_b, 3);
        check("sat.err_cw8", err_a, 6);
        check("sat.seen", seen_a, 4'b1000);
        check("sat.done", done_a, 0);

        // Handshake: valid held high, vec changed during WAIT
        do_reset();
        @(negedge clk);
        vec = 2'd0; z_drv = cell_nand(2'd0); vec_valid = 1;
        prev = 1; nf = 0; guard = 0;
        while (guard < 60) begin
            @(negedge clk);
            guard++;
            if (prev && !rdy) begin
                f_cyc[nf] = cyc;
                nf++;
                if (nf == 2) vec_valid = 0;
            end
            if (!prev && rdy) begin
                if (nf == 1) begin
                    model_sample(2'd0, z_drv);
                    z_drv = cell_nand(2'd3);
                end else begin
                    model_sample(2'd3, z_drv);
                    break;
                end
            end
            if (nf == 1 && !rdy && cyc == f_cyc[0] + 2) vec = 2'd3;
            prev = rdy;
        end
        check("hs.acceptances", nf, 2);
        if (nf == 2) check("hs.accept_period", f_cyc[1] - f_cyc[0], SETTLE + 2);
        @(negedge clk);
        m_done = m_done | (&m_seen);
        check_all("hs");
        check("hs.seen", seen_a, 4'b1001);

        // Clear coinciding with SAMPLE drops that sample
        apply_vec(2'd3, 1'b1);
        @(negedge clk);
        vec = 2'd1; z_drv = cell_nand(2'd1) ^ 1'b1; vec_valid = 1;
        @(negedge clk);
        vec_valid = 0;
        repeat (SETTLE) @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        model_clear();
        check_all("clr_sample");
        @(negedge clk);
        check_all("clr_sample2");

        // Clear during WAIT: the in-flight check still counts
        @(negedge clk);
        vec = 2'd2; z_drv = cell_nand(2'd2) ^ 1'b1; vec_valid = 1;
        @(negedge clk);
        vec_valid = 0;
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        model_clear();
        low = 0;
        while (rdy == 0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check("clr_wait.ready_returned", rdy, 1);
        model_sample(2'd2, z_drv);
        @(negedge clk);
        check_all("clr_wait");

        // Reset during WAIT, with vec_valid held through reset
        @(negedge clk);
        vec = 2'd0; z_drv = cell_nand(2'd0); vec_valid = 1;
        @(negedge clk);
        check("rst_wait.busy", rdy, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        model_clear();
        check_all("rst_wait");
        reset = 0; vec_valid = 0;
        @(negedge clk);
        check_all("rst_wait2");

        // Randomized traffic with occasional faults and clears
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                clear = 1;
                @(negedge clk);
                clear = 0;
                model_clear();
                check_all("rand_clear");
            end
            apply_vec(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        // Unknown cell output: coverage still records the vector
        do_reset();
        @(negedge clk);
        vec = 2'd2; z_drv = 1'bx; vec_valid = 1;
        @(negedge clk);
        vec_valid = 0;
        low = 0;
        while (rdy == 0 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check("x.ready_low_cycles", low, SETTLE + 1);
        @(negedge clk);
        check("x.seen_bit", seen_a[2], 1);
        xflag = (z_drv !== cell_nand(2'd2));
        if (xflag) $display("note: 4-state compare flags z=%b on vector 2 as a mismatch", z_drv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
